// File: rtl/rvfi_check_pkg.sv
// Shared definitions for the rvfi_*_check family of monitors: error-kind bit positions
// within the err_kind mask.
package rvfi_check_pkg;

    localparam int ERR_RS1   = 0;
    localparam int ERR_RS2   = 1;
    localparam int ERR_X0    = 2;
    localparam int ERR_ORDER = 3;
    localparam int ERR_VALID = 4;
    localparam int ERR_W     = 5;

    typedef logic [ERR_W-1:0] err_kind_t;

endpackage

// File: rtl/rvfi_shadow_slot.sv
// One tracked architectural register: shadow value, written flag, and per-channel rs1/rs2
// comparison against the value as seen after the lower-numbered channels of the same cycle.
module rvfi_shadow_slot #(
    parameter int NRET      = 1,
    parameter int XLEN      = 32,
    parameter int ZERO_INIT = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [4:0]           track_idx,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*5-1:0]    rvfi_rs1_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rs1_rdata,
    input  logic [NRET*5-1:0]    rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rs2_rdata,
    input  logic [NRET*5-1:0]    rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
    output logic [NRET-1:0]      rs1_mismatch,
    output logic [NRET-1:0]      rs2_mismatch
);

    logic [XLEN-1:0] shadow_reg, shadow_next;
    logic            written_reg, written_next;
    logic            slot_en;

    assign slot_en = (track_idx != 5'd0);

    // Walk channels in index order; each channel's reads are checked before its own write
    // is folded in, so a same-instruction rd write never satisfies its own rs check.
    always_comb begin
        shadow_next  = shadow_reg;
        written_next = written_reg;
        rs1_mismatch = '0;
        rs2_mismatch = '0;
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k] && slot_en) begin
                if (written_next && rvfi_rs1_addr[k*5 +: 5] == track_idx &&
                    rvfi_rs1_rdata[k*XLEN +: XLEN] != shadow_next)
                    rs1_mismatch[k] = 1'b1;
                if (written_next && rvfi_rs2_addr[k*5 +: 5] == track_idx &&
                    rvfi_rs2_rdata[k*XLEN +: XLEN] != shadow_next)
                    rs2_mismatch[k] = 1'b1;
                if (rvfi_rd_addr[k*5 +: 5] == track_idx) begin
                    shadow_next  = rvfi_rd_wdata[k*XLEN +: XLEN];
                    written_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_reg  <= '0;
            written_reg <= (ZERO_INIT != 0);
        end else begin
            shadow_reg  <= shadow_next;
            written_reg <= written_next;
        end
    end

endmodule

// File: rtl/rvfi_multi_reg_check.sv
// RVFI register-consistency monitor: shadow-register read checks, x0 check, valid compaction
// and gap-free rvfi_order tracking across NRET retire channels; errors reported one cycle later.
module rvfi_multi_reg_check
    import rvfi_check_pkg::*;
#(
    parameter int NRET      = 1,
    parameter int XLEN      = 32,
    parameter int ORDER_W   = 64,
    parameter int NSHADOW   = 2,
    parameter int ZERO_INIT = 0,
    parameter int X0_CHECK  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NSHADOW*5-1:0]    track_idx,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*ORDER_W-1:0] rvfi_order,
    input  logic [NRET*5-1:0]       rvfi_rs1_addr,
    input  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata,
    input  logic [NRET*5-1:0]       rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0]    rvfi_rs2_rdata,
    input  logic [NRET*5-1:0]       rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]    rvfi_rd_wdata,
    output logic                    err_valid,
    output logic [ERR_W-1:0]        err_kind,
    output logic [NRET-1:0]         err_chan,
    output logic                    err_sticky,
    output logic [CNT_W-1:0]        err_count
);

    logic [NRET-1:0]    rs1_mm [NSHADOW];
    logic [NRET-1:0]    rs2_mm [NSHADOW];
    logic [NRET-1:0]    rs1_any, rs2_any, gap_c, x0_c, order_c;
    logic [ORDER_W-1:0] expected_reg, expected_next;
    logic               order_seen_reg, order_seen_next;
    err_kind_t          kind_c;
    logic [NRET-1:0]    chan_c;

    logic               err_valid_reg;
    err_kind_t          err_kind_reg;
    logic [NRET-1:0]    err_chan_reg;
    logic               err_sticky_reg;
    logic [CNT_W-1:0]   err_count_reg;

    genvar gi;

    generate
        for (gi = 0; gi < NSHADOW; gi++) begin : g_slot
            rvfi_shadow_slot #(
                .NRET      (NRET),
                .XLEN      (XLEN),
                .ZERO_INIT (ZERO_INIT)
            ) u_slot (
                .clk            (clk),
                .resetn         (resetn),
                .track_idx      (track_idx[gi*5 +: 5]),
                .rvfi_valid     (rvfi_valid),
                .rvfi_rs1_addr  (rvfi_rs1_addr),
                .rvfi_rs1_rdata (rvfi_rs1_rdata),
                .rvfi_rs2_addr  (rvfi_rs2_addr),
                .rvfi_rs2_rdata (rvfi_rs2_rdata),
                .rvfi_rd_addr   (rvfi_rd_addr),
                .rvfi_rd_wdata  (rvfi_rd_wdata),
                .rs1_mismatch   (rs1_mm[gi]),
                .rs2_mismatch   (rs2_mm[gi])
            );
        end

        for (gi = 0; gi < NRET; gi++) begin : g_chan
            // A valid channel above any invalid one breaks compaction.
            if (gi == 0) begin : g_first
                assign gap_c[gi] = 1'b0;
            end else begin : g_rest
                assign gap_c[gi] = rvfi_valid[gi] & ~(&rvfi_valid[gi-1:0]);
            end
            assign x0_c[gi] = (X0_CHECK != 0) && rvfi_valid[gi] &&
                ((rvfi_rs1_addr[gi*5 +: 5] == 5'd0 && rvfi_rs1_rdata[gi*XLEN +: XLEN] != '0) ||
                 (rvfi_rs2_addr[gi*5 +: 5] == 5'd0 && rvfi_rs2_rdata[gi*XLEN +: XLEN] != '0));
        end
    endgenerate

    always_comb begin
        rs1_any = '0;
        rs2_any = '0;
        for (int s = 0; s < NSHADOW; s++) begin
            rs1_any = rs1_any | rs1_mm[s];
            rs2_any = rs2_any | rs2_mm[s];
        end
    end

    // The first valid channel ever seen establishes the base; after a mismatch the expected
    // value resyncs to the offending order so a single gap is reported once.
    always_comb begin
        expected_next   = expected_reg;
        order_seen_next = order_seen_reg;
        order_c         = '0;
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k]) begin
                if (!order_seen_next) begin
                    expected_next   = rvfi_order[k*ORDER_W +: ORDER_W];
                    order_seen_next = 1'b1;
                end
                order_c[k]    = (rvfi_order[k*ORDER_W +: ORDER_W] != expected_next);
                expected_next = rvfi_order[k*ORDER_W +: ORDER_W] + 1'b1;
            end
        end
    end

    always_comb begin
        kind_c = '0;
        chan_c = '0;
        for (int k = 0; k < NRET; k++) begin
            kind_c[ERR_RS1]   = kind_c[ERR_RS1]   | rs1_any[k];
            kind_c[ERR_RS2]   = kind_c[ERR_RS2]   | rs2_any[k];
            kind_c[ERR_X0]    = kind_c[ERR_X0]    | x0_c[k];
            kind_c[ERR_ORDER] = kind_c[ERR_ORDER] | order_c[k];
            kind_c[ERR_VALID] = kind_c[ERR_VALID] | gap_c[k];
            chan_c[k] = rs1_any[k] | rs2_any[k] | x0_c[k] | order_c[k] | gap_c[k];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            expected_reg   <= '0;
            order_seen_reg <= 1'b0;
            err_valid_reg  <= 1'b0;
            err_kind_reg   <= '0;
            err_chan_reg   <= '0;
            err_sticky_reg <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            expected_reg   <= expected_next;
            order_seen_reg <= order_seen_next;
            err_valid_reg  <= |kind_c;
            err_kind_reg   <= kind_c;
            err_chan_reg   <= chan_c;
            err_sticky_reg <= err_sticky_reg | (|kind_c);
            if ((|kind_c) && !(&err_count_reg))
                err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign err_valid  = err_valid_reg;
    assign err_kind   = err_kind_reg;
    assign err_chan   = err_chan_reg;
    assign err_sticky = err_sticky_reg;
    assign err_count  = err_count_reg;

endmodule
